// File: rtl/demux1to2_buffered_pkg.sv
// -----------------------------------------------------------------------------
// demux1to2_buffered_pkg
// Shared definitions for the buffered 1-to-2 demultiplexer:
//   - channel index constants (CH0 / CH1)
//   - default data and counter widths
//   - slot occupancy type (EMPTY / FULL)
//   - single-bit 2:1 select helper used for the in_ready steering
// -----------------------------------------------------------------------------
package demux1to2_buffered_pkg;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_CNTWIDTH = 8;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Occupancy of a one-entry holding register.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // One-bit 2:1 multiplexer: returns a1 when sel is set, else a0.
    function automatic logic mux2to1_bit(input logic sel, input logic a0, input logic a1);
        logic y;
        if (sel == CH1) begin
            y = a1;
        end else begin
            y = a0;
        end
        return y;
    endfunction

endpackage

// File: rtl/demux1to2_buffered_if.sv
// -----------------------------------------------------------------------------
// demux1to2_buffered_if
// Bundles the upstream valid/ready/address/data port, both downstream
// channel handshakes and the per-channel delivered-word counters.
//   master : the environment (upstream producer and both consumers)
//   slave  : the demultiplexer itself
// Parameters: width (data width), cntwidth (delivered-word counter width).
// -----------------------------------------------------------------------------
interface demux1to2_buffered_if
    import demux1to2_buffered_pkg::*;
#(
    parameter int width    = DEFAULT_WIDTH,
    parameter int cntwidth = DEFAULT_CNTWIDTH
);

    logic                in_valid;
    logic                in_ready;
    logic                address;
    logic [width-1:0]    in_data;

    logic                out0_valid;
    logic                out0_ready;
    logic [width-1:0]    out0_data;

    logic                out1_valid;
    logic                out1_ready;
    logic [width-1:0]    out1_data;

    logic [cntwidth-1:0] count0;
    logic [cntwidth-1:0] count1;

    modport master (
        output in_valid, address, in_data, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data, count0, count1
    );

    modport slave (
        input  in_valid, address, in_data, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data, count0, count1
    );

endinterface

// File: rtl/demux1to2_buffered_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// One-entry holding register with valid/ready output handshake and a
// wrapping count of delivered words.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   load           write load_data into the slot at the next edge
//   load_data      word to store
//   out_ready      consumer takes the held word this cycle
//   slot_ready     slot can take a load this cycle (empty or draining)
//   out_valid      slot is FULL
//   out_data       held word (retains last value when EMPTY)
//   count          delivered-word counter, wraps modulo 2^cntwidth
// The parent only asserts load while slot_ready is high.
// -----------------------------------------------------------------------------
module demux_slot
    import demux1to2_buffered_pkg::*;
#(
    parameter int width    = DEFAULT_WIDTH,
    parameter int cntwidth = DEFAULT_CNTWIDTH
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic [width-1:0]    load_data,
    input  logic                out_ready,
    output logic                slot_ready,
    output logic                out_valid,
    output logic [width-1:0]    out_data,
    output logic [cntwidth-1:0] count
);

    slot_state_e         state_q, state_d;
    logic [width-1:0]    data_q,  data_d;
    logic [cntwidth-1:0] count_q, count_d;
    logic                drain_s;

    // State, data and counter registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= {width{1'b0}};
            count_q <= {cntwidth{1'b0}};
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    // Next-state: a load wins over a drain, so drain+reload keeps the slot FULL.
    always_comb begin
        drain_s = (state_q == SLOT_FULL) && out_ready;
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        if (load) begin
            state_d = SLOT_FULL;
            data_d  = load_data;
        end else if (drain_s) begin
            state_d = SLOT_EMPTY;
        end else begin
            state_d = state_q;
        end
        // A drain-and-reload in one cycle delivers exactly one word.
        if (drain_s) begin
            count_d = count_q + {{(cntwidth-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Outputs: everything but slot_ready comes straight from flops.
    always_comb begin
        out_valid  = (state_q == SLOT_FULL);
        out_data   = data_q;
        count      = count_q;
        slot_ready = (state_q == SLOT_EMPTY) || out_ready;
    end

endmodule

// File: rtl/demux1to2_buffered.sv
// -----------------------------------------------------------------------------
// demux1to2_buffered
// Registered 1-to-2 demultiplexer. Each accepted input word is steered by
// address into one of two one-entry holding registers; each channel drains
// independently through its own valid/ready handshake and counts the words
// it delivers.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      demux1to2_buffered_if.slave (input handshake, two output
//            channels, two delivered-word counters)
// in_ready depends only on address and the addressed channel's valid/ready,
// so there is no combinational path from in_valid or in_data to any output.
// -----------------------------------------------------------------------------
module demux1to2_buffered
    import demux1to2_buffered_pkg::*;
#(
    parameter int width    = DEFAULT_WIDTH,
    parameter int cntwidth = DEFAULT_CNTWIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    demux1to2_buffered_if.slave       bus
);

    logic slot0_ready_s;
    logic slot1_ready_s;
    logic in_ready_s;
    logic accept_s;
    logic load0_s;
    logic load1_s;

    // Address decode: in_ready follows the addressed channel only.
    always_comb begin
        in_ready_s = mux2to1_bit(bus.address, slot0_ready_s, slot1_ready_s);
        accept_s   = bus.in_valid && in_ready_s;
        load0_s    = accept_s && (bus.address == CH0);
        load1_s    = accept_s && (bus.address == CH1);
    end

    assign bus.in_ready = in_ready_s;

    demux_slot #(
        .width    (width),
        .cntwidth (cntwidth)
    ) u_slot0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load0_s),
        .load_data  (bus.in_data),
        .out_ready  (bus.out0_ready),
        .slot_ready (slot0_ready_s),
        .out_valid  (bus.out0_valid),
        .out_data   (bus.out0_data),
        .count      (bus.count0)
    );

    demux_slot #(
        .width    (width),
        .cntwidth (cntwidth)
    ) u_slot1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load1_s),
        .load_data  (bus.in_data),
        .out_ready  (bus.out1_ready),
        .slot_ready (slot1_ready_s),
        .out_valid  (bus.out1_valid),
        .out_data   (bus.out1_data),
        .count      (bus.count1)
    );

endmodule

// File: doc/demux1to2_buffered.md
Name: demux1to2_buffered

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshakes. It is the distribution counterpart of mux2to1 in the sequential multiplier datapath.
- Steers each accepted input word to one of two output channels, selected by address. Each channel has a one-entry holding register.
- Used to route multiplier partial results or products to one of two consumers, each of which can stall independently.
- Keeps a per-channel count of delivered words for debug and sequencing.

Parameters:
- width, 8, data width of the input and both outputs
- cntwidth, 8, width of each per-channel delivered-word counter

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream presents in_data/address this cycle
- in_ready  output  1  block accepts the word this cycle
- address  input  1  destination channel (0 or 1); sampled only when in_valid=1
- in_data  input  width  word to route
- out0_valid  output  1  channel 0 holding register full
- out0_ready  input  1  channel 0 consumer takes the word this cycle
- out0_data  output  width  channel 0 holding register contents
- out1_valid  output  1  channel 1 holding register full
- out1_ready  input  1  channel 1 consumer takes the word this cycle
- out1_data  output  width  channel 1 holding register contents
- count0  output  cntwidth  words delivered on channel 0 (out0_valid && out0_ready), wraps
- count1  output  cntwidth  words delivered on channel 1, wraps

Behaviour:
- Reset (reset_n=0, asynchronous):
  - out0_valid=out1_valid=0; out0_data=out1_data=0; count0=count1=0.
  - Takes effect immediately, independent of clk.
  - Reset mid-operation discards held words; no partial delivery.
- Channel state, per channel k: EMPTY (outk_valid=0) or FULL (outk_valid=1). Only the slot flag is stateful; there is no other FSM.
- Handshake:
  - in_ready = !slot[address].valid || outk_ready, where k=address. This is combinational from address, out0_valid/out1_valid and out0_ready/out1_ready.
  - in_ready is evaluated for the addressed channel only; the other channel's state is irrelevant to it.
  - Accept = in_valid && in_ready. On accept, slot[address] loads in_data and valid=1 at the next edge. Latency is 1 cycle from accept to outk_valid.
- Drain: outk_valid && outk_ready at an edge delivers the word. The slot goes EMPTY unless it is reloaded in the same cycle.
- Simultaneous drain and accept on the same channel: the slot reloads with new data and outk_valid stays 1. The channel sustains full throughput of 1 word/cycle.
- Accept to channel A while channel B drains: the two proceed independently.
- Blocked input:
  - If in_valid && !in_ready, nothing changes.
  - Upstream must hold in_data and address stable until accepted. The block does not check this.
- Output rules:
  - outk_data holds its value while FULL and not drained; data never changes under outk_valid=1 without a handshake.
  - When EMPTY, outk_data retains its last value (don't-care to consumers).
- Counters:
  - countk increments by 1 on each delivery on channel k and wraps modulo 2^cntwidth.
  - A same-cycle drain-and-reload counts 1 (the drained word).
- Out-of-range: address is 1 bit, so no invalid destination exists. address is ignored when in_valid=0.
- No combinational path from in_valid or in_data to any output.

Decomposition:
- Shared package: channel index constants CH0=0 and CH1=0b1, and the default width.
- Natural sub-module: demux_slot, a one-entry holding register with valid/ready, load, drain and delivered-count logic. Instantiate it twice.
- Top level holds the address decode and the in_ready mux, which may reuse mux2to1 with width=1.

Test Plan:
- Reset then idle:
  - Stimulus: assert reset_n=0 mid-stream with both slots FULL.
  - Required: out0_valid=out1_valid=0 and count0=count1=0 immediately, without waiting for a clk edge.
- Single route:
  - Stimulus: in_valid=1, address=1, in_data=0xA5, out1_ready=0.
  - Required: next cycle out1_valid=1 and out1_data=0xA5; out0_valid stays 0. A second word 0x3C to address=1 sees in_ready=0.
  - Then: raise out1_ready and count1 becomes 1.
- Backpressure isolation:
  - Stimulus: channel 0 FULL with out0_ready=0; present 0x11 to address=1.
  - Required: in_ready=1 and out1_data=0x11 next cycle; out0_data is unchanged.
- Streaming:
  - Stimulus: out0_ready=1 held; 10 back-to-back words 0x00..0x09 to address=0.
  - Required: in_ready=1 every cycle; out0_data follows one cycle behind; count0=10 at the end.
- Counter wrap:
  - Stimulus: with cntwidth=8, deliver 257 words on channel 1.
  - Required: count1=1; count0=0.
- Alternating destinations:
  - Stimulus: addresses 0,1,0,1 with data 0x10,0x20,0x30,0x40 and both readies high.
  - Required: channel 0 sees 0x10 then 0x30; channel 1 sees 0x20 then 0x40; count0=count1=2.
